mod_updown_counter: RTL and testbench

Parametrised synchronous up/down modulo counter with enable, parallel load and cascade carry/borrow; the general-purpose successor to the team's 2-bit enable counter. It is used for FIFO read/write pointers, occupancy tracking and timer prescalers. Counters of any width or modulus are built directly, or cascaded through `carry`/`borrow` into a following stage's `en`.

---
 rtl/mod_updown_counter.sv | 104 ++++++++++
 tb/tb_mod_updown_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_updown_counter
// Brief    : Synchronous up/down modulo counter with enable, clamped parallel
//            load and cascade carry/borrow. Define MOD_COUNTER_SATURATE_EN to
//            hold at the end values instead of wrapping.
// Revision : 1.0
// ============================================================================
module mod_updown_counter #(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = longint'(1) << WIDTH,
  parameter longint RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             borrow,
  output logic             tc,
  output logic             load_err
);

  // Comparisons are made one bit wider so MODULUS = 2**WIDTH needs no special case.
  localparam logic [WIDTH:0]   c_max_ext = MODULUS[WIDTH:0] - 1'b1;
  localparam logic [WIDTH-1:0] c_max     = c_max_ext[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_reset   = RESET_VAL[WIDTH-1:0];

`ifdef MOD_COUNTER_SATURATE_EN
  localparam bit c_saturate = 1'b1;
`else
  localparam bit c_saturate = 1'b0;
`endif

  logic [WIDTH-1:0] r_count_q;
  logic [WIDTH-1:0] w_count_d;
  logic             r_load_err_q;
  logic             w_load_err_d;

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_lv_ext;
  logic             w_in_range;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_q_ext    = {1'b0, r_count_q};
  assign w_lv_ext   = {1'b0, load_val};
  assign w_in_range = (w_q_ext <= c_max_ext);
  assign w_at_max   = (w_q_ext == c_max_ext);
  assign w_at_zero  = (r_count_q == '0);

  always_comb begin
    w_count_d    = r_count_q;
    w_load_err_d = 1'b0;
    if (clear) begin
      w_count_d = c_reset;
    end else if (load) begin
      if (w_lv_ext > c_max_ext) begin
        w_count_d    = c_max;
        w_load_err_d = 1'b1;
      end else begin
        w_count_d = load_val;
      end
    end else if (en) begin
      // An out-of-range state recovers to zero on the next enabled count.
      if (!w_in_range) begin
        w_count_d = '0;
      end else if (up) begin
        if (w_at_max) begin
          w_count_d = c_saturate ? c_max : '0;
        end else begin
          w_count_d = r_count_q + 1'b1;
        end
      end else begin
        if (w_at_zero) begin
          w_count_d = c_saturate ? '0 : c_max;
        end else begin
          w_count_d = r_count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_count_q    <= c_reset;
      r_load_err_q <= 1'b0;
    end else begin
      r_count_q    <= w_count_d;
      r_load_err_q <= w_load_err_d;
    end
  end

  assign q        = r_count_q;
  assign load_err = r_load_err_q;
  assign carry    = en & up & w_at_max & ~load & ~clear;
  assign borrow   = en & ~up & w_at_zero & ~load & ~clear;
  assign tc       = up ? w_at_max : w_at_zero;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_updown_counter
// Brief    : Self-checking bench: vector table, random traffic against an
//            arithmetic reference model, and a two-stage cascade.
// Revision : 1.0
// ============================================================================
module tb_mod_updown_counter;

  localparam int c_mod = 10;
`ifdef MOD_COUNTER_SATURATE_EN
  localparam bit c_sat = 1'b1;
`else
  localparam bit c_sat = 1'b0;
`endif
  localparam int c_up_wrap = c_sat ? 9 : 0;
  localparam int c_dn_wrap = c_sat ? 0 : 9;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       clear, en, up, load;
  logic [3:0] load_val, q;
  logic       carry, borrow, tc, load_err;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut (
    .clock(clock), .clear(clear), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q), .carry(carry), .borrow(borrow), .tc(tc),
    .load_err(load_err)
  );

  logic       c_clear, c_en, c_up, c_load_lo, c_load_hi;
  logic [3:0] c_lv_lo, c_lv_hi, lo_q, hi_q;
  logic       lo_carry, lo_borrow, lo_tc, lo_err;
  logic       hi_carry, hi_borrow, hi_tc, hi_err;
  logic       hi_en;
  assign hi_en = lo_carry | lo_borrow;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) u_lo (
    .clock(clock), .clear(c_clear), .en(c_en), .up(c_up), .load(c_load_lo),
    .load_val(c_lv_lo), .q(lo_q), .carry(lo_carry), .borrow(lo_borrow),
    .tc(lo_tc), .load_err(lo_err)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_hi (
    .clock(clock), .clear(c_clear), .en(hi_en), .up(c_up), .load(c_load_hi),
    .load_val(c_lv_hi), .q(hi_q), .carry(hi_carry), .borrow(hi_borrow),
    .tc(hi_tc), .load_err(hi_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_q      = 0;

  typedef struct {
    bit clr, e, u, ld;
    int lv;
    bit x_c, x_b, x_t;
    int x_q;
    bit x_err;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: counter value as an integer in 0..c_mod-1, next value by modular arithmetic.
  function automatic int model_next(input int cur, input bit clr, e, u, ld, input int lv);
    if (clr) return 0;
    if (ld) return (lv >= c_mod) ? c_mod - 1 : lv;
    if (!e) return cur;
    if (cur >= c_mod) return 0;
    if (u) return (c_sat && cur == c_mod - 1) ? cur : (cur + 1) % c_mod;
    return (c_sat && cur == 0) ? 0 : (cur + c_mod - 1) % c_mod;
  endfunction

  task automatic apply(input bit clr, e, u, ld, input int lv,
                       output bit a_c, a_b, a_t, output int a_q, output bit a_err);
    @(negedge clock);
    clear = clr; en = e; up = u; load = ld; load_val = 4'(lv);
    #1;
    a_c = carry; a_b = borrow; a_t = tc;
    @(posedge clock);
    #1;
    a_q = int'(q); a_err = load_err;
  endtask

  task automatic mstep(input bit clr, e, u, ld, input int lv, input string tag);
    bit a_c, a_b, a_t, a_err;
    int a_q;
    bit x_c, x_b, x_t, x_err;
    int x_q;
    x_c   = e && u && (m_q == c_mod - 1) && !ld && !clr;
    x_b   = e && !u && (m_q == 0) && !ld && !clr;
    x_t   = u ? (m_q == c_mod - 1) : (m_q == 0);
    x_q   = model_next(m_q, clr, e, u, ld, lv);
    x_err = !clr && ld && (lv >= c_mod);
    apply(clr, e, u, ld, lv, a_c, a_b, a_t, a_q, a_err);
    chk({tag, ".carry"}, int'(a_c), int'(x_c));
    chk({tag, ".borrow"}, int'(a_b), int'(x_b));
    chk({tag, ".tc"}, int'(a_t), int'(x_t));
    chk({tag, ".q"}, a_q, x_q);
    chk({tag, ".load_err"}, int'(a_err), int'(x_err));
    m_q = x_q;
  endtask

  task automatic cstep(input bit clr, e, u, ld_lo, ld_hi, input int lv_lo, lv_hi);
    @(negedge clock);
    c_clear = clr; c_en = e; c_up = u; c_load_lo = ld_lo; c_load_hi = ld_hi;
    c_lv_lo = 4'(lv_lo); c_lv_hi = 4'(lv_hi);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit a_c, a_b, a_t, a_err;
    int a_q;

    clear = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    c_clear = 1'b1; c_en = 1'b0; c_up = 1'b1; c_load_lo = 1'b0; c_load_hi = 1'b0;
    c_lv_lo = '0; c_lv_hi = '0;

    //                clr e u ld lv   c b t  q          err
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b0, 0, 1'b0,1'b0,1'b0, 1,         1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b1, 7, 1'b0,1'b0,1'b0, 7,         1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0, 0, 1'b0,1'b0,1'b0, 8,         1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b1,1'b0, 0, 1'b0,1'b0,1'b0, 9,         1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b1,1'b0, 0, 1'b1,1'b0,1'b1, c_up_wrap, 1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b1,1'b1, 0, 1'b0,1'b0,c_sat, 0,        1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0, 0, 1'b0,1'b1,1'b1, c_dn_wrap, 1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b1, 9, 1'b0,1'b0,!c_sat, 9,       1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0, 9,         1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b0, 0, 1'b0,1'b0,1'b1, 9,         1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b1,13, 1'b0,1'b0,1'b1, 9,         1'b1};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0, 9,         1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b1,15, 1'b0,1'b0,1'b0, 9,         1'b1};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b1,15, 1'b0,1'b0,1'b0, 9,         1'b1};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b1, 0, 1'b0,1'b0,1'b0, 0,         1'b0};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b1, 0, 1'b0,1'b0,1'b1, 0,         1'b0};
    tbl[16] = '{1'b1,1'b1,1'b0,1'b0, 0, 1'b0,1'b0,1'b1, 0,         1'b0};
    tbl[17] = '{1'b1,1'b1,1'b1,1'b1,13, 1'b0,1'b0,1'b0, 0,         1'b0};
    tbl[18] = '{1'b0,1'b1,1'b1,1'b0, 0, 1'b0,1'b0,1'b0, 1,         1'b0};
    tbl[19] = '{1'b1,1'b1,1'b1,1'b0, 0, 1'b0,1'b0,1'b0, 0,         1'b0};

    apply(1'b1, 1'b0, 1'b1, 1'b0, 0, a_c, a_b, a_t, a_q, a_err);
    chk("reset.q", a_q, 0);
    chk("reset.load_err", int'(a_err), 0);

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].clr, tbl[i].e, tbl[i].u, tbl[i].ld, tbl[i].lv, a_c, a_b, a_t, a_q, a_err);
      chk($sformatf("tbl[%0d].carry", i), int'(a_c), int'(tbl[i].x_c));
      chk($sformatf("tbl[%0d].borrow", i), int'(a_b), int'(tbl[i].x_b));
      chk($sformatf("tbl[%0d].tc", i), int'(a_t), int'(tbl[i].x_t));
      chk($sformatf("tbl[%0d].q", i), a_q, tbl[i].x_q);
      chk($sformatf("tbl[%0d].load_err", i), int'(a_err), int'(tbl[i].x_err));
    end
    m_q = tbl[19].x_q;

    mstep(1'b1, 1'b0, 1'b1, 1'b0, 0, "wrap_clear");
    for (int k = 0; k < 12; k++) mstep(1'b0, 1'b1, 1'b1, 1'b0, 0, $sformatf("wrap_up[%0d]", k));
    mstep(1'b0, 1'b0, 1'b0, 1'b1, 1, "down_load1");
    for (int k = 0; k < 3; k++) mstep(1'b0, 1'b1, 1'b0, 1'b0, 0, $sformatf("down[%0d]", k));

    for (int k = 0; k < 400; k++) begin
      bit r_clr, r_e, r_u, r_ld;
      int r_lv;
      r_clr = ($urandom_range(0, 31) == 0);
      r_ld  = ($urandom_range(0, 7) == 0);
      r_e   = ($urandom_range(0, 3) != 0);
      r_u   = 1'($urandom_range(0, 1));
      r_lv  = int'($urandom_range(0, 15));
      mstep(r_clr, r_e, r_u, r_ld, r_lv, $sformatf("rand[%0d]", k));
    end

`ifdef MOD_COUNTER_SATURATE_EN
    mstep(1'b0, 1'b0, 1'b1, 1'b1, 9, "sat_load9");
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b0, 0, a_c, a_b, a_t, a_q, a_err);
      chk($sformatf("sat_up[%0d].carry", k), int'(a_c), 1);
      chk($sformatf("sat_up[%0d].q", k), a_q, 9);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 0, a_c, a_b, a_t, a_q, a_err);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 0, a_c, a_b, a_t, a_q, a_err);
      chk($sformatf("sat_dn[%0d].borrow", k), int'(a_b), 1);
      chk($sformatf("sat_dn[%0d].q", k), a_q, 0);
    end
`endif

    cstep(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("casc_reset.lo", int'(lo_q), 3);
    chk("casc_reset.hi", int'(hi_q), 0);
    cstep(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    chk("casc_load.lo", int'(lo_q), 0);
    chk("casc_load.hi", int'(hi_q), 0);
    for (int v = 1; v <= 19; v++) begin
      @(negedge clock);
      c_clear = 1'b0; c_en = 1'b1; c_up = 1'b1; c_load_lo = 1'b0; c_load_hi = 1'b0;
      #1;
      chk($sformatf("casc[%0d].lo_carry", v), int'(lo_carry), int'(((v - 1) % 10) == 9));
      @(posedge clock);
      #1;
      chk($sformatf("casc[%0d].lo", v), int'(lo_q), v % 10);
      chk($sformatf("casc[%0d].hi", v), int'(hi_q), v / 10);
    end
    cstep(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5, 1);
    chk("casc_15.lo", int'(lo_q), 5);
    chk("casc_15.hi", int'(hi_q), 1);
    cstep(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("casc_clear.lo", int'(lo_q), 3);
    chk("casc_clear.hi", int'(hi_q), 0);
    chk("casc_clear.lo_err", int'(lo_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
